// File: rtl/memarbiter.sv
// Single-port arbiter serialising core data access and instruction fetch
// onto one variable-latency memory, stalling the core until both complete.
module memarbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ireq,
    input  logic [ADDR_WIDTH-1:0] iadr,
    input  logic                  dread,
    input  logic                  dwrite,
    input  logic [ADDR_WIDTH-1:0] dadr,
    input  logic [DATA_WIDTH-1:0] dwd,
    output logic [DATA_WIDTH-1:0] irdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] madr,
    output logic [DATA_WIDTH-1:0] mwd,
    output logic                  mread,
    output logic                  mwrite,
    input  logic [DATA_WIDTH-1:0] mrdata,
    input  logic                  mready,
    output logic                  error,
    output logic [31:0]           stallcount
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] INST = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [WW-1:0] wait_cnt;
    logic          busy;
    logic          timeout;
    logic          done;
    logic          data_req;
    logic          data_rd;

    assign data_req = dread | dwrite;
    // A simultaneous read and write is resolved as a write.
    assign data_rd  = dread & ~dwrite;
    assign busy     = (state == DATA) | (state == INST);
    assign timeout  = busy & ~mready & (wait_cnt == WAIT_MAX);
    assign done     = busy & (mready | timeout);

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        madr       = '0;
        mwd        = '0;
        mread      = 1'b0;
        mwrite     = 1'b0;
        case (state)
            IDLE: begin
                stall = data_req | ireq;
                if (data_req)
                    state_next = DATA;
                else if (ireq)
                    state_next = INST;
            end
            DATA: begin
                stall  = 1'b1;
                madr   = dadr;
                mwd    = dwd;
                mwrite = dwrite;
                mread  = data_rd;
                if (done)
                    state_next = ireq ? INST : DONE;
            end
            INST: begin
                stall = 1'b1;
                madr  = iadr;
                mread = 1'b1;
                if (done)
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            irdata     <= '0;
            drdata     <= '0;
            error      <= 1'b0;
            stallcount <= '0;
        end else begin
            state <= state_next;
            if (busy && !done)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout)
                error <= 1'b1;
            // Timed-out reads deliver zero rather than stale bus data.
            if (state == DATA && done && data_rd)
                drdata <= mready ? mrdata : '0;
            if (state == INST && done)
                irdata <= mready ? mrdata : '0;
            if (stall && !(&stallcount))
                stallcount <= stallcount + 32'd1;
        end
    end

endmodule
